mem_access_arbiter: RTL

//   Shares the single 256x8 data memory between the instruction-fetch port (read-only) and the

---
 rtl/mem_access_arbiter_if.sv | 46 ++++
 rtl/mem_access_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_arbiter_if.sv
// Bus bundle between the nRisc fetch / load-store stages, the arbiter and
// the 256x8 data memory. The arbiter uses the slave view; the requesters
// plus memory side use the master view.
interface mem_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // fetch port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    // load/store port
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;
    // memory control pins
    logic              mem_ctrl;
    logic              mem_op;
    logic [ADDR_W-1:0] mem_index;
    logic [ADDR_W-1:0] mem_index_lw;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;
    // status
    logic              busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_rdata, mem_resp,
        output if_ack, if_rdata, ls_ack, ls_rdata,
        output mem_ctrl, mem_op, mem_index, mem_index_lw, mem_wdata,
        output busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata,
        output mem_rdata, mem_resp,
        input  if_ack, if_rdata, ls_ack, ls_rdata,
        input  mem_ctrl, mem_op, mem_index, mem_index_lw, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter: shares the single data memory between the read-only
// fetch port and the load/store port. Each port uses level req / 1-cycle ack;
// the memory uses a toggle handshake (mem_ctrl edge starts an access, a
// mem_resp edge ends it). Round-robin between ports when both request.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYC cycles (adds the sticky o_err output).
module mem_access_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic i_clock,
    input  logic i_reset,
`ifdef MEM_ARB_TIMEOUT_EN
    output logic o_err,
`endif
    mem_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic              r_resp_q;      // registered mem_resp
    logic              r_exp;         // resp level that means "access done"
    logic              r_last_ls;     // last completed grant: 1 = LS, 0 = IF
    logic              r_grant_ls;    // current grant
    logic              r_grant_we;    // current grant is a store
    logic              r_mem_ctrl;
    logic              r_mem_op;
    logic [ADDR_W-1:0] r_mem_index;
    logic [ADDR_W-1:0] r_mem_index_lw;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_ack;
    logic              r_ls_ack;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;

    logic w_any_req;
    logic w_pick_ls;
    logic w_complete;
    logic w_timeout;
    logic w_start;
    logic w_fire;
    logic w_finish;

    assign w_any_req  = bus.if_req | bus.ls_req;
    assign w_complete = (r_resp_q == r_exp);

    // Single requester wins outright; with both pending the port that did
    // not get the last grant wins, so contention always alternates.
    always_comb begin
        w_pick_ls = 1'b0;
        if (bus.ls_req && !bus.if_req)
            w_pick_ls = 1'b1;
        else if (bus.ls_req && bus.if_req)
            w_pick_ls = ~r_last_ls;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_cnt <= 8'd0;
        else if (r_state == S_WAIT)
            r_cnt <= r_cnt + 8'd1;
        else
            r_cnt <= 8'd0;
    end

    assign w_timeout = (r_state == S_WAIT) && !w_complete &&
                       (r_cnt == 8'(TIMEOUT_CYC - 1));

    // Sticky error flag: once a timeout is seen it stays until reset.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_err <= 1'b0;
        else if (w_timeout)
            r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYC;
    assign w_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic and one-cycle strobes for the datapath.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_fire   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_start = 1'b1;
                    w_next  = S_SETUP;
                end
            end
            S_SETUP: begin
                // lines were set up last cycle; now they are stable
                w_fire = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_complete || w_timeout) begin
                    w_finish = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: grant/memory-line latching, toggle, capture, ack pulse.
    // In IDLE exp continually tracks resp_q, so a late response edge from an
    // access killed by reset (or a timeout) is absorbed before the next one.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_resp_q       <= 1'b0;
            r_exp          <= 1'b0;
            r_last_ls      <= 1'b1;
            r_grant_ls     <= 1'b0;
            r_grant_we     <= 1'b0;
            r_mem_ctrl     <= 1'b0;
            r_mem_op       <= 1'b0;
            r_mem_index    <= '0;
            r_mem_index_lw <= '0;
            r_mem_wdata    <= '0;
            r_if_ack       <= 1'b0;
            r_ls_ack       <= 1'b0;
            r_if_rdata     <= '0;
            r_ls_rdata     <= '0;
        end else begin
            r_resp_q <= bus.mem_resp;
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;

            if (r_state == S_IDLE)
                r_exp <= r_resp_q;

            if (w_start) begin
                r_grant_ls <= w_pick_ls;
                r_grant_we <= w_pick_ls & bus.ls_we;
                if (w_pick_ls && bus.ls_we) begin
                    r_mem_op    <= 1'b1;
                    r_mem_index <= bus.ls_addr;
                    r_mem_wdata <= bus.ls_wdata;
                end else if (w_pick_ls) begin
                    r_mem_op       <= 1'b0;
                    r_mem_index_lw <= bus.ls_addr;
                end else begin
                    // fetch is always a read
                    r_mem_op       <= 1'b0;
                    r_mem_index_lw <= bus.if_addr;
                end
            end

            if (w_fire) begin
                r_mem_ctrl <= ~r_mem_ctrl;
                r_exp      <= ~r_exp;
            end

            if (w_finish) begin
                if (w_timeout)
                    r_exp <= r_resp_q;
                if (r_grant_ls) begin
                    r_ls_ack <= 1'b1;
                    if (!r_grant_we)
                        r_ls_rdata <= w_timeout ? '0 : bus.mem_rdata;
                end else begin
                    r_if_ack   <= 1'b1;
                    r_if_rdata <= w_timeout ? '0 : bus.mem_rdata;
                end
            end

            if (r_state == S_DONE)
                r_last_ls <= r_grant_ls;
        end
    end

    assign bus.mem_ctrl     = r_mem_ctrl;
    assign bus.mem_op       = r_mem_op;
    assign bus.mem_index    = r_mem_index;
    assign bus.mem_index_lw = r_mem_index_lw;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.if_ack       = r_if_ack;
    assign bus.ls_ack       = r_ls_ack;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.ls_rdata     = r_ls_rdata;
    assign bus.busy         = (r_state != S_IDLE);

endmodule
